seq_nibble_divider: RTL and testbench
=====================================

Name: seq_nibble_divider

Overview:
- Sequential restoring divider: the inverse companion to the nibble adder datapath.
- Computes quotient and remainder of two unsigned WIDTH-bit operands by repeated trial subtraction, one quotient bit per clock.
- Sits beside the adder in the arithmetic unit that feeds the seven-segment display path.
- Start/done handshake; results held stable for the display logic.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits (legal range 2..16).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a division; sampled only when busy=0.
- dividend  in  WIDTH  unsigned dividend; sampled with start.
- divisor  in  WIDTH  unsigned divisor; sampled with start.
- busy  out  1  high while iterating (CALC state).
- done  out  1  one-cycle pulse: results valid.
- quotient  out  WIDTH  unsigned quotient; held until next accepted start.
- remainder  out  WIDTH  unsigned remainder; held until next accepted start.
- div_by_zero  out  1  set with done when divisor was 0; held like quotient.

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous, active-low. While reset_n=0: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, all internal registers=0.
- Reset asserted mid-operation aborts the division. No done is produced for it.
- States:
  - IDLE: accept when start=1.
  - CALC: iterate.
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- Acceptance: start is accepted on a rising edge when state is IDLE or DONE (busy=0). This allows back-to-back operations.
- start while busy=1 is ignored entirely; operands are not re-sampled.
- On acceptance with divisor!=0:
  - Latch dividend into shift register Q and divisor into D.
  - Clear partial remainder R (WIDTH+1 bits), set iteration counter=0, go to CALC.
  - Clear div_by_zero. quotient and remainder outputs keep their old values until DONE.
- CALC iteration (one per clock, WIDTH iterations total):
  - {R,Q} shifted left 1.
  - T = R_shifted - {1'b0,D}, computed at WIDTH+1 bits.
  - If T non-negative (MSB=0): R=T and Q[0]=1; else R=R_shifted and Q[0]=0.
  - Counter increments. After the iteration with counter=WIDTH-1, go to DONE.
- Entering DONE: quotient=Q, remainder=R[WIDTH-1:0].
- Latency: start sampled at edge E0; busy=1 from E0 to E0+WIDTH; done=1 for the cycle following edge E0+WIDTH. That is WIDTH+1 edges from acceptance to done.
- Divisor=0 on acceptance:
  - Skip CALC and go to DONE at the next edge; done=1 one cycle after acceptance.
  - quotient=all ones, remainder=dividend, div_by_zero=1. busy stays 0.
- Invariant for divisor!=0: dividend == quotient*divisor + remainder, and remainder < divisor.
- Outputs hold between operations: quotient, remainder and div_by_zero hold their values after DONE until the next accepted operation reaches DONE.

Decomposition:
- Shared package/include holds state encodings (ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2) and the default WIDTH constant.
- One natural sub-module: nibble_trial_subtractor. It is a combinational WIDTH+1-bit ripple subtractor (a - b, borrow out), built from the existing full-adder cell with inverted b and carry-in=1. It is instantiated once for the trial subtraction.
- FSM, counter and shift registers live in the top module.

Test Plan:
- Reset, then dividend=13, divisor=3, start for 1 cycle:
  - busy high for 4 cycles, done pulses on the 5th edge.
  - quotient=4, remainder=1, div_by_zero=0.
- Corner values:
  - 15/1 gives q=15, r=0.
  - 7/9 gives q=0, r=7.
  - 0/5 gives q=0, r=0.
  - Exhaustive sweep of all 256 (WIDTH=4) pairs with divisor!=0 against the invariant.
- Divide by zero, 9/0: done exactly 1 cycle after acceptance, busy never high, q=15, r=9, div_by_zero=1. A following 8/2 gives div_by_zero=0, q=4, r=0.
- start re-asserted with different operands (14/5) during busy of 12/4: ignored; result q=3, r=0; only one done pulse.
- Back-to-back: start held high in the DONE cycle with 10/3 is accepted; the second done arrives 5 edges later with q=3, r=1. The first results hold until then.
- reset_n pulsed low asynchronously (mid-cycle) during CALC of 11/2:
  - Outputs go to 0 immediately; no done is produced.
  - After release, 11/2 runs normally: q=5, r=1.

Source files
------------

// File: rtl/seq_nibble_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand width and the full-adder cell used by the trial subtractor.
package seq_nibble_divider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Full-adder cell, returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

endpackage

// File: rtl/seq_nibble_divider_subtractor.sv
// Combinational N-bit ripple subtractor (a - b) made of full-adder cells with
// b inverted and carry-in tied high; borrow is the inverted final carry.
module nibble_trial_subtractor
    import seq_nibble_divider_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH + 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign {carry[i+1], diff[i]} = full_add(a[i], ~b[i], carry[i]);
    end

    assign borrow = ~carry[N];

endmodule

// File: rtl/seq_nibble_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/done
// handshake, results held stable for the display path until the next result.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start
// ST_CALC | one trial subtraction per clock, WIDTH iterations
// ST_DONE | done pulse for one cycle; start here is accepted back-to-back
module seq_nibble_divider
    import seq_nibble_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   t_diff;
    logic             t_borrow;
    logic             q_bit;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    assign r_sh = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

    nibble_trial_subtractor #(
        .N (WIDTH + 1)
    ) u_trial_sub (
        .a      (r_sh),
        .b      ({1'b0, d_reg}),
        .diff   (t_diff),
        .borrow (t_borrow)
    );

    // R stays below D throughout CALC, so "no borrow" is exactly "T MSB clear".
    assign q_bit  = ~t_borrow;
    assign r_next = q_bit ? t_diff : r_sh;
    assign q_next = {q_reg[WIDTH-2:0], q_bit};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_CALC: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next[WIDTH-1:0];
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    if (start) begin
                        if (divisor != '0) begin
                            q_reg       <= dividend;
                            d_reg       <= divisor;
                            r_reg       <= '0;
                            cnt         <= '0;
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            state       <= ST_CALC;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_nibble_divider.sv
// Self-checking bench for seq_nibble_divider: expected results are queued when
// an operation is driven and compared when done pulses.
module tb_seq_nibble_divider;

    localparam int W = 4;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;

    seq_nibble_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sb_push(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            check_val("expected_done", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check_val("quotient", quotient, e.q);
                check_val("remainder", remainder, e.r);
                check_val("div_by_zero", div_by_zero, e.z);
                if (e.b != 0) begin
                    check_val("inv_eq", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
                    check_val("inv_lt", remainder < e.b, 1);
                end
            end
        end
    end

    // Drive one operation at a negedge and follow it to its done pulse.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        bit seen;
        sb_push(a, b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        lat  = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (done) seen = 1;
            else check_val("busy_during_op", busy, (b != 0));
        end
        check_val("done_seen", seen, 1);
        check_val("latency", lat, (b != 0) ? W + 1 : 1);
        check_val("busy_at_done", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        bit seen;
        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_quotient", quotient, 0);
        check_val("rst_remainder", remainder, 0);
        check_val("rst_dbz", div_by_zero, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(13, 3);
        repeat (2) @(negedge clk);
        run_op(15, 1);
        run_op(7, 9);
        run_op(0, 5);

        run_op(9, 0);
        run_op(8, 2);
        @(negedge clk);

        // start during busy must be ignored
        d0 = done_cnt;
        sb_push(12, 4);
        dividend = 12;
        divisor  = 4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        dividend = 14;
        divisor  = 5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check_val("ignored_start_one_done", done_cnt - d0, 1);

        // back-to-back: second start presented in the DONE cycle
        run_op(12, 4);
        sb_push(10, 3);
        dividend = 10;
        divisor  = 3;
        start    = 1'b1;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            start = 1'b0;
            check_val("b2b_busy", busy, 1);
            check_val("b2b_hold_q", quotient, 3);
            check_val("b2b_hold_r", remainder, 0);
        end
        @(negedge clk);
        check_val("b2b_done", done, 1);
        @(negedge clk);

        // asynchronous reset during CALC
        d0 = done_cnt;
        sb_push(11, 2);
        dividend = 11;
        divisor  = 2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_val("arst_busy", busy, 0);
        check_val("arst_done", done, 0);
        check_val("arst_quotient", quotient, 0);
        check_val("arst_remainder", remainder, 0);
        check_val("arst_dbz", div_by_zero, 0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check_val("arst_no_done", done_cnt - d0, 0);
        run_op(11, 2);
        @(negedge clk);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(W'(a), W'(b));
            end
        end

        repeat (3) @(negedge clk);
        check_val("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
